// File: rtl/ava_vec_pkg.sv
// Shared types and port roles for the vector op sequencer and its lane ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ava_vec_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_MAX = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  // Register-file port roles: two read ports for sources, one write port for results.
  localparam int PORT_SRC1 = 0;
  localparam int PORT_SRC2 = 1;
  localparam int PORT_DST  = 2;

endpackage

// File: rtl/vector_lane_alu.sv
// Element-wise lane ALU: ADD, SUB (a-b), MUL (low W bits), signed MAX; wraps, no flags.
// Latency: combinational.
// Backpressure: none; result follows the operands in the same cycle.
module vector_lane_alu
  import ava_vec_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [1:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);

  // Select the operation; all results truncate to W bits.
  always_comb begin
    o_y = '0;
    case (op_e'(i_op))
      OP_ADD:  o_y = i_a + i_b;
      OP_SUB:  o_y = i_a - i_b;
      OP_MUL:  o_y = i_a * i_b;
      OP_MAX:  o_y = ($signed(i_a) > $signed(i_b)) ? i_a : i_b;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/vector_op_sequencer.sv
// Runs one element-wise vector op: reads src1/src2 on ports 0/1, writes dst on port 2.
// Latency: element i read in cycle 1+i, written at end of cycle 3+i; done in cycle len_eff+3.
// Backpressure: none toward the register file; cmd_ready is low from accept until done.
module vector_op_sequencer
  import ava_vec_pkg::*;
#(
  parameter int W  = 16,
  parameter int L  = 32,
  parameter int NP = 4,
  parameter int A  = 5
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic [1:0]   i_cmd_op,
  input  logic [A-1:0] i_cmd_src1,
  input  logic [A-1:0] i_cmd_src2,
  input  logic [A-1:0] i_cmd_dst,
  input  logic [A:0]   i_cmd_len,
  output logic         o_busy,
  output logic         o_done,
  output logic [A-1:0] o_rf_address [NP],
  output logic         o_rf_write   [NP],
  output logic [W-1:0] o_rf_datain  [NP],
  input  logic [W-1:0] i_rf_dataout [NP]
);

  localparam logic [A:0] LEN_MAX = (A+1)'(L);

  seq_state_e   r_state, w_next_state;
  logic [1:0]   r_op;
  logic [A-1:0] r_src1, r_src2, r_dst, r_idx, r_last;
  logic         r_s1_vld, r_s2_vld;
  logic [W-1:0] r_s1_a, r_s1_b, r_s2_y;
  logic [A-1:0] r_s1_addr, r_s2_addr;
  logic         w_accept, w_issue;
  logic [A:0]   w_len_eff;
  logic [W-1:0] w_alu_y;
  logic [W-1:0] w_unused_rd;

  // Lengths beyond the register file clamp to a full sweep.
  assign w_len_eff = (i_cmd_len > LEN_MAX) ? LEN_MAX : i_cmd_len;

  // State register; reset aborts any command in flight.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next state and handshake outputs; a new command may be taken in the done cycle.
  always_comb begin
    w_next_state = r_state;
    o_cmd_ready  = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    w_issue      = 1'b0;
    case (r_state)
      IDLE: o_cmd_ready = 1'b1;
      ISSUE: begin
        o_busy  = 1'b1;
        w_issue = 1'b1;
        if (r_idx == r_last) w_next_state = DRAIN;
      end
      DRAIN: begin
        if (!r_s1_vld && !r_s2_vld) begin
          o_done       = 1'b1;
          o_cmd_ready  = 1'b1;
          w_next_state = IDLE;
        end else begin
          o_busy = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
    w_accept = o_cmd_ready && i_cmd_valid;
    if (w_accept) w_next_state = (i_cmd_len == '0) ? DRAIN : ISSUE;
  end

  // Latch the command on accept, then step the element index while issuing.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_op   <= '0;
      r_src1 <= '0;
      r_src2 <= '0;
      r_dst  <= '0;
      r_last <= '0;
      r_idx  <= '0;
    end else if (w_accept) begin
      r_op   <= i_cmd_op;
      r_src1 <= i_cmd_src1;
      r_src2 <= i_cmd_src2;
      r_dst  <= i_cmd_dst;
      r_last <= A'(w_len_eff - 1'b1);
      r_idx  <= '0;
    end else if (w_issue) begin
      r_idx  <= r_idx + 1'b1;
    end
  end

  // Two-stage pipeline: operands plus dst address, then result plus dst address.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_s1_vld  <= 1'b0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s1_addr <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_y    <= '0;
      r_s2_addr <= '0;
    end else begin
      r_s1_vld <= w_issue;
      if (w_issue) begin
        r_s1_a    <= i_rf_dataout[PORT_SRC1];
        r_s1_b    <= i_rf_dataout[PORT_SRC2];
        r_s1_addr <= r_dst + r_idx;
      end
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_y    <= w_alu_y;
        r_s2_addr <= r_s1_addr;
      end
    end
  end

  vector_lane_alu #(.W(W)) u_alu (
    .i_op (r_op),
    .i_a  (r_s1_a),
    .i_b  (r_s1_b),
    .o_y  (w_alu_y)
  );

  // Drive register-file ports; everything not actively used is held at zero.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      o_rf_address[p] = '0;
      o_rf_write[p]   = 1'b0;
      o_rf_datain[p]  = '0;
    end
    if (w_issue) begin
      o_rf_address[PORT_SRC1] = r_src1 + r_idx;
      o_rf_address[PORT_SRC2] = r_src2 + r_idx;
    end
    if (r_s2_vld) begin
      o_rf_address[PORT_DST] = r_s2_addr;
      o_rf_write[PORT_DST]   = 1'b1;
      o_rf_datain[PORT_DST]  = r_s2_y;
    end
  end

  // Read data on the write port and the idle ports is never consumed.
  always_comb begin
    w_unused_rd = '0;
    for (int p = PORT_DST; p < NP; p++) w_unused_rd = w_unused_rd ^ i_rf_dataout[p];
  end

endmodule

// File: tb/tb_vector_op_sequencer.sv
// Directed bench for vector_op_sequencer with a behavioural register-file model.
// Latency: checks done cycle and write timing against hand-computed values.
// Backpressure: commands are only presented while cmd_ready is high.
module tb_vector_op_sequencer;
  import ava_vec_pkg::*;

  localparam int W  = 16;
  localparam int L  = 32;
  localparam int NP = 4;
  localparam int A  = 5;

  logic         clk = 1'b0;
  logic         n_reset;
  logic         cmd_valid, cmd_ready, busy, done;
  logic [1:0]   cmd_op;
  logic [A-1:0] cmd_src1, cmd_src2, cmd_dst;
  logic [A:0]   cmd_len;
  logic [A-1:0] rf_address [NP];
  logic         rf_write   [NP];
  logic [W-1:0] rf_datain  [NP];
  logic [W-1:0] rf_dataout [NP];

  logic [W-1:0] mem [L];
  logic         pk_we;
  logic [A-1:0] pk_addr;
  logic [W-1:0] pk_dat;
  int           wr_cnt = 0;
  int           p3_cnt = 0;
  int           done_cnt = 0;

  int           n_checks = 0;
  int           n_pass = 0;
  logic [A-1:0] a0_log [64];

  vector_op_sequencer #(.W(W), .L(L), .NP(NP), .A(A)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_op     (cmd_op),
    .i_cmd_src1   (cmd_src1),
    .i_cmd_src2   (cmd_src2),
    .i_cmd_dst    (cmd_dst),
    .i_cmd_len    (cmd_len),
    .o_busy       (busy),
    .o_done       (done),
    .o_rf_address (rf_address),
    .o_rf_write   (rf_write),
    .o_rf_datain  (rf_datain),
    .i_rf_dataout (rf_dataout)
  );

  always #5 clk = ~clk;

  // Register-file model: combinational read, X on a port that is writing.
  always_comb begin
    for (int p = 0; p < NP; p++) rf_dataout[p] = rf_write[p] ? 'x : mem[rf_address[p]];
  end

  // Register-file writes, bench preloads and event counters.
  always @(posedge clk) begin
    if (pk_we) mem[pk_addr] <= pk_dat;
    for (int p = 0; p < NP; p++) if (rf_write[p]) mem[rf_address[p]] <= rf_datain[p];
    if (rf_write[2]) wr_cnt <= wr_cnt + 1;
    if (rf_write[3]) p3_cnt <= p3_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int a, input logic [W-1:0] d);
    pk_we = 1'b1; pk_addr = A'(a); pk_dat = d;
    step();
    pk_we = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input int s1, input int s2, input int d, input int len);
    chk("cmd_ready_before_accept", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op;
    cmd_src1 = A'(s1); cmd_src2 = A'(s2); cmd_dst = A'(d); cmd_len = (A+1)'(len);
    step();
    cmd_valid = 1'b0;
  endtask

  // Returns the cycle (accept edge ends cycle 0) in which done is seen.
  task automatic wait_done(output int cyc, output bit hs_ok);
    cyc = 1; hs_ok = 1'b1;
    while (done !== 1'b1 && cyc < 100) begin
      if (cyc < 64) a0_log[cyc] = rf_address[0];
      if (busy !== 1'b1 || cmd_ready !== 1'b0) hs_ok = 1'b0;
      step();
      cyc++;
    end
  endtask

  task automatic run_single(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp, input string tag);
    int cyc; bit hs;
    poke(0, a); poke(8, b);
    send_cmd(op, 0, 8, 20, 1);
    wait_done(cyc, hs);
    chk({tag, "_done_cycle"}, cyc, 4);
    step();
    chk({tag, "_result"}, mem[20], exp);
  endtask

  initial begin
    int cyc, w0, d0;
    bit hs;
    n_reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_src1 = '0; cmd_src2 = '0;
    cmd_dst = '0; cmd_len = '0; pk_we = 1'b0; pk_addr = '0; pk_dat = '0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_write2", rf_write[2], 0);
    chk("rst_addr0", rf_address[0], 0);
    step(); step();
    n_reset = 1'b1;
    step();

    // Basic ADD
    for (int k = 0; k < 4; k++) begin poke(k, W'(k + 1)); poke(8 + k, W'(10 * (k + 1))); end
    w0 = wr_cnt;
    send_cmd(OP_ADD, 0, 8, 16, 4);
    chk("add_addr0_c1", rf_address[0], 0);
    chk("add_addr1_c1", rf_address[1], 8);
    chk("add_write01_c1", {rf_write[0], rf_write[1]}, 0);
    wait_done(cyc, hs);
    chk("add_done_cycle", cyc, 7);
    chk("add_busy_ready_hold", hs, 1);
    chk("add_ready_on_done", cmd_ready, 1);
    chk("add_write_count", wr_cnt - w0, 4);
    for (int k = 0; k < 4; k++) chk("add_result", mem[16 + k], 32'(11 * (k + 1)));
    step();
    chk("idle_busy", busy, 0);

    // Single-element ops
    run_single(OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, "sub");
    run_single(OP_MUL, 16'h0100, 16'h0100, 16'h0000, "mul");
    run_single(OP_MAX, 16'hFFFF, 16'h0001, 16'h0001, "max_neg");
    run_single(OP_MAX, 16'h8000, 16'h7FFF, 16'h7FFF, "max_min");

    // Address wrap
    poke(30, 5); poke(31, 6); poke(0, 7); poke(1, 8);
    for (int k = 2; k < 6; k++) poke(k, 1);
    send_cmd(OP_ADD, 30, 2, 12, 4);
    wait_done(cyc, hs);
    chk("wrap_done_cycle", cyc, 7);
    chk("wrap_rd_addr_c1", a0_log[1], 30);
    chk("wrap_rd_addr_c2", a0_log[2], 31);
    chk("wrap_rd_addr_c3", a0_log[3], 0);
    chk("wrap_rd_addr_c4", a0_log[4], 1);
    step();
    for (int k = 0; k < 4; k++) chk("wrap_result", mem[12 + k], 32'(6 + k));

    // Length clamp: len 40 sweeps all 32 entries in place
    poke(7, 16'h1234);
    w0 = wr_cnt;
    send_cmd(OP_ADD, 0, 0, 0, 40);
    wait_done(cyc, hs);
    chk("clamp_done_cycle", cyc, 35);
    step();
    chk("clamp_write_count", wr_cnt - w0, 32);
    chk("clamp_value", mem[7], 16'h2468);

    // Zero length, then a command accepted in the done cycle
    poke(0, 3); poke(1, 4); poke(8, 10); poke(9, 20);
    w0 = wr_cnt;
    send_cmd(OP_ADD, 0, 8, 16, 0);
    wait_done(cyc, hs);
    chk("len0_done_cycle", cyc, 1);
    chk("len0_ready_on_done", cmd_ready, 1);
    chk("len0_no_write", wr_cnt - w0, 0);
    send_cmd(OP_ADD, 0, 8, 28, 2);
    chk("b2b_busy_c1", busy, 1);
    wait_done(cyc, hs);
    chk("b2b_done_cycle", cyc, 5);
    step();
    chk("b2b_result0", mem[28], 13);
    chk("b2b_result1", mem[29], 24);

    // In-place destination
    for (int k = 0; k < 8; k++) begin poke(4 + k, W'(k + 1)); poke(20 + k, W'(16 * (k + 1))); end
    send_cmd(OP_ADD, 4, 20, 4, 8);
    wait_done(cyc, hs);
    chk("inplace_done_cycle", cyc, 11);
    chk("inplace_busy_ready_hold", hs, 1);
    step();
    for (int k = 0; k < 8; k++) chk("inplace_result", mem[4 + k], 32'(17 * (k + 1)));

    // Reset in the middle of a command
    poke(0, 1); poke(1, 2); poke(8, 10); poke(9, 20);
    for (int k = 24; k < 32; k++) poke(k, 16'hDEAD);
    w0 = wr_cnt; d0 = done_cnt;
    send_cmd(OP_ADD, 0, 8, 24, 8);
    for (int k = 0; k < 4; k++) step();
    chk("mid_write_before_rst", rf_write[2], 1);
    n_reset = 1'b0;
    #1;
    chk("mid_write_in_rst", rf_write[2], 0);
    chk("mid_ready_in_rst", cmd_ready, 1);
    step(); step();
    n_reset = 1'b1;
    for (int k = 0; k < 12; k++) step();
    chk("mid_no_done", done_cnt - d0, 0);
    chk("mid_write_count", wr_cnt - w0, 2);
    chk("mid_ready_after", cmd_ready, 1);
    chk("mid_busy_after", busy, 0);
    chk("mid_elem0", mem[24], 11);
    chk("mid_elem1", mem[25], 22);
    chk("mid_elem2_untouched", mem[26], 16'hDEAD);
    chk("mid_elem7_untouched", mem[31], 16'hDEAD);

    chk("port3_never_written", p3_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
